// File: rtl/snake_frame_seq.sv
// Frame address sequencer for the 7-segment snake ROM: a prescaled frame clock
// steps the address forward/reverse with wrap, under run/pause/clear/step control.
module snake_frame_seq #(
  parameter int unsigned TICK_DIV = 2_500_000,
  parameter int unsigned FRAMES   = 20,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              clear,
  input  logic              step,
  input  logic              dir,
  input  logic [1:0]        speed,
  output logic [ADDR_W-1:0] addr,
  output logic              frame_tick,
  output logic              wrap,
  output logic              running
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAMES - 1);
  localparam logic [CNT_W-1:0]  DIV_W     = CNT_W'(TICK_DIV);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               frame_tick_q, frame_tick_d;
  logic               wrap_q, wrap_d;
  logic               running_q, running_d;
  logic               step_q, step_d;
  logic [CNT_W-1:0]   limit;
  logic               adv;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!pause && start) state_d = RUN;
        RUN:     if (pause) state_d = PAUSE;
        PAUSE:   if (!pause && start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Advance only when staying in the same state, so clear/pause/start beat a
  // coincident period end or step edge.
  always_comb begin
    limit        = (DIV_W >> speed) - CNT_W'(1);
    adv          = 1'b0;
    cnt_d        = '0;
    addr_d       = addr_q;
    wrap_d       = 1'b0;
    step_d       = step;
    running_d    = (state_d == RUN);

    if (state_q == RUN && state_d == RUN) begin
      if (cnt_q >= limit) begin
        adv = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (state_q == PAUSE && state_d == PAUSE && step && !step_q) begin
      adv = 1'b1;
    end

    if (adv) begin
      if (dir) begin
        if (addr_q == '0) begin
          addr_d = LAST_ADDR;
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q - ADDR_W'(1);
        end
      end else begin
        if (addr_q >= LAST_ADDR) begin
          addr_d = '0;
          wrap_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
    end

    if (clear) begin
      addr_d = '0;
    end

    frame_tick_d = adv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      frame_tick_q <= 1'b0;
      wrap_q       <= 1'b0;
      running_q    <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      frame_tick_q <= frame_tick_d;
      wrap_q       <= wrap_d;
      running_q    <= running_d;
      step_q       <= step_d;
    end
  end

  assign addr       = addr_q;
  assign frame_tick = frame_tick_q;
  assign wrap       = wrap_q;
  assign running    = running_q;

endmodule

// File: tb/tb_snake_frame_seq.sv
// Directed bench for snake_frame_seq with TICK_DIV=8, FRAMES=20.
module tb_snake_frame_seq;

  logic       clk = 1'b0;
  logic       rst, start, pause, clear, step, dir;
  logic [1:0] speed;
  logic [4:0] addr;
  logic       frame_tick, wrap, running;

  int unsigned tests = 0;
  int unsigned fails = 0;

  snake_frame_seq #(
    .TICK_DIV(8),
    .FRAMES  (20),
    .ADDR_W  (5),
    .CNT_W   (22)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .clear     (clear),
    .step      (step),
    .dir       (dir),
    .speed     (speed),
    .addr      (addr),
    .frame_tick(frame_tick),
    .wrap      (wrap),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
    step = 1'b0; dir = 1'b0; speed = 2'd0;
    cyc(); cyc();
    rst = 1'b0;
    tests++;
    if (addr !== 5'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", addr); end
    tests++;
    if ({frame_tick, wrap, running} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got tick/wrap/run=%b want 000", {frame_tick, wrap, running});
    end
  endtask

  // Full forward lap at speed 0: tick every 8 clocks, 19 -> 0 wraps.
  task automatic test_forward();
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL fwd_running got %b want 1", running); end
    for (int k = 1; k <= 20; k++) begin
      for (int i = 0; i < 7; i++) begin
        cyc();
        tests++;
        if (frame_tick !== 1'b0) begin
          fails++; $display("FAIL fwd_quiet frame %0d clk %0d got tick=%b want 0", k, i, frame_tick);
        end
      end
      cyc();
      tests++;
      if (frame_tick !== 1'b1 || addr !== 5'(k % 20) || wrap !== (k == 20)) begin
        fails++;
        $display("FAIL fwd_tick frame %0d got tick=%b addr=%0d wrap=%b want 1/%0d/%b",
                 k, frame_tick, addr, wrap, k % 20, (k == 20));
      end
    end
  endtask

  task automatic test_reverse();
    logic [4:0] exp_a [3] = '{5'd19, 5'd18, 5'd17};
    logic       exp_w [3] = '{1'b1, 1'b0, 1'b0};
    dir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) begin
        cyc();
        tests++;
        if (frame_tick !== 1'b0) begin fails++; $display("FAIL rev_quiet got tick=%b want 0", frame_tick); end
      end
      cyc();
      tests++;
      if (frame_tick !== 1'b1 || addr !== exp_a[k] || wrap !== exp_w[k]) begin
        fails++;
        $display("FAIL rev_tick %0d got tick=%b addr=%0d wrap=%b want 1/%0d/%b",
                 k, frame_tick, addr, wrap, exp_a[k], exp_w[k]);
      end
    end
    dir = 1'b0;
  endtask

  // At addr 17, prescaler 0; run to prescaler 5 then jump to speed 2.
  task automatic test_speed();
    for (int i = 0; i < 5; i++) cyc();
    speed = 2'd2;
    cyc();
    tests++;
    if (frame_tick !== 1'b1 || addr !== 5'd18) begin
      fails++; $display("FAIL speed_jump got tick=%b addr=%0d want 1/18", frame_tick, addr);
    end
    cyc();
    tests++;
    if (frame_tick !== 1'b0) begin fails++; $display("FAIL speed_gap got tick=%b want 0", frame_tick); end
    cyc();
    tests++;
    if (frame_tick !== 1'b1 || addr !== 5'd19) begin
      fails++; $display("FAIL speed_period got tick=%b addr=%0d want 1/19", frame_tick, addr);
    end
    cyc(); cyc();
    tests++;
    if (addr !== 5'd0 || wrap !== 1'b1) begin
      fails++; $display("FAIL speed_wrap got addr=%0d wrap=%b want 0/1", addr, wrap);
    end
    for (int i = 0; i < 14; i++) cyc();
    tests++;
    if (addr !== 5'd7 || frame_tick !== 1'b1) begin
      fails++; $display("FAIL speed_to7 got addr=%0d tick=%b want 7/1", addr, frame_tick);
    end
  endtask

  task automatic test_pause_step();
    speed = 2'd0;
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    tests++;
    if (running !== 1'b0 || addr !== 5'd7) begin
      fails++; $display("FAIL pause_enter got run=%b addr=%0d want 0/7", running, addr);
    end
    for (int i = 0; i < 12; i++) cyc();
    tests++;
    if (addr !== 5'd7 || frame_tick !== 1'b0) begin
      fails++; $display("FAIL pause_hold got addr=%0d tick=%b want 7/0", addr, frame_tick);
    end
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      cyc();
      tests++;
      if (frame_tick !== 1'b1 || addr !== 5'(8 + p)) begin
        fails++; $display("FAIL step_edge %0d got tick=%b addr=%0d want 1/%0d", p, frame_tick, addr, 8 + p);
      end
      for (int i = 0; i < 3; i++) begin
        cyc();
        tests++;
        if (frame_tick !== 1'b0 || addr !== 5'(8 + p)) begin
          fails++; $display("FAIL step_held %0d got tick=%b addr=%0d want 0/%0d", p, frame_tick, addr, 8 + p);
        end
      end
      step = 1'b0;
      cyc();
    end
  endtask

  task automatic test_clear_priority();
    for (int p = 0; p < 2; p++) begin
      step = 1'b1; cyc();
      step = 1'b0; cyc();
    end
    tests++;
    if (addr !== 5'd12) begin fails++; $display("FAIL clr_setup got addr=%0d want 12", addr); end
    start = 1'b1; pause = 1'b1; clear = 1'b1;
    cyc();
    start = 1'b0; pause = 1'b0; clear = 1'b0;
    tests++;
    if (addr !== 5'd0 || running !== 1'b0 || frame_tick !== 1'b0) begin
      fails++; $display("FAIL clr_all got addr=%0d run=%b tick=%b want 0/0/0", addr, running, frame_tick);
    end
    step = 1'b1; cyc();
    tests++;
    if (addr !== 5'd0 || frame_tick !== 1'b0) begin
      fails++; $display("FAIL clr_idle_step got addr=%0d tick=%b want 0/0", addr, frame_tick);
    end
    step = 1'b0; cyc();
    start = 1'b1; cyc();
    tests++;
    if (running !== 1'b1) begin fails++; $display("FAIL sp_run got run=%b want 1", running); end
    pause = 1'b1; cyc();
    start = 1'b0; pause = 1'b0;
    tests++;
    if (running !== 1'b0) begin fails++; $display("FAIL sp_pause got run=%b want 0", running); end
    step = 1'b1; cyc();
    step = 1'b0;
    tests++;
    if (addr !== 5'd1 || frame_tick !== 1'b1) begin
      fails++; $display("FAIL sp_in_pause got addr=%0d tick=%b want 1/1", addr, frame_tick);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    speed = 2'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 28; i++) cyc();
    tests++;
    if (addr !== 5'd15) begin fails++; $display("FAIL rst_setup got addr=%0d want 15", addr); end
    speed = 2'd0;
    for (int i = 0; i < 3; i++) cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    tests++;
    if (addr !== 5'd0 || {frame_tick, wrap, running} !== 3'b000) begin
      fails++; $display("FAIL rst_mid got addr=%0d tick/wrap/run=%b want 0/000", addr, {frame_tick, wrap, running});
    end
    for (int i = 0; i < 10; i++) begin
      cyc();
      tests++;
      if (frame_tick !== 1'b0) begin fails++; $display("FAIL rst_no_tick got tick=%b want 0", frame_tick); end
    end
    step = 1'b1; cyc();
    tests++;
    if (addr !== 5'd0 || frame_tick !== 1'b0) begin
      fails++; $display("FAIL rst_idle_step got addr=%0d tick=%b want 0/0", addr, frame_tick);
    end
    step = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      tests++;
      if (frame_tick !== 1'b0) begin fails++; $display("FAIL rst_full_period got tick=%b want 0", frame_tick); end
    end
    cyc();
    tests++;
    if (frame_tick !== 1'b1 || addr !== 5'd1) begin
      fails++; $display("FAIL rst_first_tick got tick=%b addr=%0d want 1/1", frame_tick, addr);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_speed();
    test_pause_step();
    test_clear_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
